// File: rtl/ex_div_ctrl.sv
// ex_div_ctrl: execute-stage controller in front of the iterative divider.
// It latches DIV/DIVU operands and issues a start using a ready/start
// handshake. It stalls IF..EX while the divide runs and turns a pipeline
// flush into a divider cancel. It holds the quotient/remainder as LO/HI
// until the instruction leaves EX, so one instruction is issued only once.

module ex_div_ctrl #(
    parameter int N_WIDTH = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_div_req,
    input  logic               i_div_signed,
    input  logic [N_WIDTH-1:0] i_opa,
    input  logic [N_WIDTH-1:0] i_opb,
    input  logic               i_flush,
    input  logic               i_pipe_stall,
    output logic               o_stall_req,
    output logic               o_result_vld,
    output logic [N_WIDTH-1:0] o_hi,
    output logic [N_WIDTH-1:0] o_lo,
    output logic               o_divstart,
    output logic [N_WIDTH-1:0] o_dividend,
    output logic [N_WIDTH-1:0] o_divisor,
    output logic               o_divsigned,
    output logic               o_cancel,
    input  logic               i_div_ready,
    input  logic               i_div_done,
    input  logic [N_WIDTH-1:0] i_quotient,
    input  logic [N_WIDTH-1:0] i_remainder
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_r;
    logic [N_WIDTH-1:0] dividend_r;
    logic [N_WIDTH-1:0] divisor_r;
    logic               divsigned_r;
    logic [N_WIDTH-1:0] hi_r;
    logic [N_WIDTH-1:0] lo_r;
    logic               divstart_r;
    logic               result_vld_r;

    logic               stall_req_s;
    logic               cancel_s;

    // Stall and cancel are combinational so that the freeze and the abort
    // take effect in the same cycle the divide enters EX or is flushed.
    always_comb begin
        stall_req_s = 1'b0;
        cancel_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                stall_req_s = i_div_req & ~i_flush;
                cancel_s    = 1'b0;
            end
            ST_ISSUE, ST_WAIT: begin
                stall_req_s = 1'b1;
                cancel_s    = i_flush;
            end
            ST_DONE: begin
                stall_req_s = 1'b0;
                cancel_s    = 1'b0;
            end
            default: begin
                stall_req_s = 1'b0;
                cancel_s    = 1'b0;
            end
        endcase
    end

    // Control FSM. The start/valid flags are registered in step with the
    // state, so the divider interface has no path from the operand inputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r      <= ST_IDLE;
            dividend_r   <= {N_WIDTH{1'b0}};
            divisor_r    <= {N_WIDTH{1'b0}};
            divsigned_r  <= 1'b0;
            hi_r         <= {N_WIDTH{1'b0}};
            lo_r         <= {N_WIDTH{1'b0}};
            divstart_r   <= 1'b0;
            result_vld_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_div_req && !i_flush) begin
                        dividend_r   <= i_opa;
                        divisor_r    <= i_opb;
                        divsigned_r  <= i_div_signed;
                        divstart_r   <= 1'b1;
                        result_vld_r <= 1'b0;
                        state_r      <= ST_ISSUE;
                    end else begin
                        divstart_r   <= 1'b0;
                        result_vld_r <= 1'b0;
                        state_r      <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (i_flush) begin
                        divstart_r <= 1'b0;
                        state_r    <= ST_IDLE;
                    end else if (i_div_ready) begin
                        // Divider samples the operands on this edge.
                        divstart_r <= 1'b0;
                        state_r    <= ST_WAIT;
                    end else begin
                        divstart_r <= 1'b1;
                        state_r    <= ST_ISSUE;
                    end
                end
                ST_WAIT: begin
                    // A flush wins over a coincident done: the result is dropped.
                    if (i_flush) begin
                        state_r <= ST_IDLE;
                    end else if (i_div_done) begin
                        lo_r         <= i_quotient;
                        hi_r         <= i_remainder;
                        result_vld_r <= 1'b1;
                        state_r      <= ST_DONE;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_DONE: begin
                    // A new request is ignored here; the result stays until EX advances.
                    if (i_flush || !i_pipe_stall) begin
                        result_vld_r <= 1'b0;
                        state_r      <= ST_IDLE;
                    end else begin
                        result_vld_r <= 1'b1;
                        state_r      <= ST_DONE;
                    end
                end
                default: begin
                    divstart_r   <= 1'b0;
                    result_vld_r <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_stall_req  = stall_req_s;
    assign o_cancel     = cancel_s;
    assign o_divstart   = divstart_r;
    assign o_result_vld = result_vld_r;
    assign o_dividend   = dividend_r;
    assign o_divisor    = divisor_r;
    assign o_divsigned  = divsigned_r;
    assign o_hi         = hi_r;
    assign o_lo         = lo_r;

endmodule

// File: doc/ex_div_ctrl.md
# ex_div_ctrl

Execute-stage divide controller sitting directly upstream of the iterative divider. It accepts DIV/DIVU from the EX stage, latches operands, and issues a start to the divider with a ready/start handshake. It stalls the pipeline for the duration of the divide, forwards pipeline flushes as a cancel, and captures quotient/remainder as LO/HI. It holds that result until the instruction leaves EX, so the same instruction never re-issues.

## Interface
- N_WIDTH, 32, operand/result width
- i_clk  in  1  clock
- i_rst  in  1  asynchronous, active-high reset
- i_div_req  in  1  DIV/DIVU instruction present in EX
- i_div_signed  in  1  1 = DIV, 0 = DIVU
- i_opa  in  N_WIDTH  dividend (rs)
- i_opb  in  N_WIDTH  divisor (rt)
- i_flush  in  1  pipeline flush/exception; kills the EX instruction
- i_pipe_stall  in  1  a later stage holds EX this cycle
- o_stall_req  out  1  request to freeze IF..EX
- o_result_vld  out  1  o_hi/o_lo valid for the EX instruction
- o_hi  out  N_WIDTH  remainder
- o_lo  out  N_WIDTH  quotient
- o_divstart  out  1  start request to divider
- o_dividend  out  N_WIDTH  latched dividend
- o_divisor  out  N_WIDTH  latched divisor
- o_divsigned  out  1  latched signedness
- o_cancel  out  1  abort to divider
- i_div_ready  in  1  divider idle/accepting
- i_div_done  in  1  divider result valid, one-cycle pulse
- i_quotient  in  N_WIDTH  divider quotient (sign-corrected)
- i_remainder  in  N_WIDTH  divider remainder (sign-corrected)

## Operation
- States:
  - IDLE: waiting for a divide.
  - ISSUE: start presented to the divider.
  - WAIT: divider running.
  - DONE: result held.
- IDLE: if i_div_req & !i_flush, latch i_opa/i_opb/i_div_signed into operand registers and go to ISSUE. Otherwise stay in IDLE.
- ISSUE: o_divstart = 1.
  - i_flush: go to IDLE, o_cancel = 1.
  - Else if i_div_ready: handshake completes, go to WAIT.
  - Else: stay in ISSUE, o_divstart stays high, operands stable.
- WAIT:
  - i_flush: o_cancel = 1, go to IDLE, discard any coincident i_div_done. Flush wins.
  - Else if i_div_done: capture i_quotient→o_lo and i_remainder→o_hi, go to DONE.
- DONE: o_result_vld = 1, o_stall_req = 0.
  - i_flush: go to IDLE.
  - Else if !i_pipe_stall: the instruction advances this cycle, go to IDLE.
  - Else: stay in DONE with o_hi/o_lo held.
  - i_div_req is ignored in DONE.
- o_stall_req = (IDLE & i_div_req & !i_flush) | ISSUE | WAIT. This is combinational, so the stall appears in the same cycle the divide enters EX.
- o_cancel = i_flush & (ISSUE | WAIT), combinational. It is never asserted in IDLE or DONE.
- o_divstart, o_dividend, o_divsigned and o_divisor are driven from registers/state only. They carry no combinational path from i_opa/i_opb.
- Divide by zero: no special handling; pass through the divider result (quotient 0).
- Result registers update only on WAIT & i_div_done & !i_flush.

## Timing
- Reset (async, i_rst = 1):
  - State = IDLE.
  - o_stall_req, o_result_vld, o_divstart and o_cancel are 0 (given i_div_req = 0).
  - o_hi, o_lo, o_dividend and o_divisor are 0; o_divsigned is 0.
- Reset mid-WAIT returns to IDLE immediately. Divider reset is handled separately.
- Handshake: the divider samples operands on the edge where o_divstart & i_div_ready. ISSUE lasts ≥1 cycle.
- Latency: result registers load on the edge where i_div_done is sampled high. o_result_vld rises the following cycle; o_stall_req falls in that same cycle.
- Total stall: 1 (IDLE request) + ISSUE cycles + divider cycles until done.
- A flush in any cycle removes o_stall_req the next cycle; o_result_vld never asserts for a flushed divide.
- No back-to-back overlap: a new divide can start only from IDLE, i.e. at least one cycle after DONE exits.

## Test plan
- Unsigned: i_div_signed = 0, i_opa = 100, i_opb = 7, divider model done after 34 cycles:
  - o_divstart for 1 cycle.
  - Stall held until DONE.
  - o_lo = 14, o_hi = 2, o_result_vld for 1 cycle.
- Signed: i_opa = 0xFFFFFFF9 (−7), i_opb = 2:
  - o_lo = 0xFFFFFFFD, o_hi = 0xFFFFFFFF.
  - o_divsigned = 1 throughout ISSUE.
- Back-pressure: i_div_ready low for 3 cycles in ISSUE:
  - o_divstart held 4 cycles, operands constant.
  - Exactly one divider start is accepted.
- Flush: i_flush in the 5th WAIT cycle:
  - o_cancel = 1 that cycle.
  - Next cycle: IDLE, o_stall_req = 0, o_result_vld never asserts.
- Flush in the same cycle as i_div_done: result registers unchanged, no o_result_vld.
- Hold: i_pipe_stall = 1 for 3 cycles in DONE with i_div_req still high:
  - o_result_vld and o_hi/o_lo held for 4 cycles.
  - No second o_divstart.
  - IDLE after i_pipe_stall drops.
